kernel_stream_sequencer: RTL and testbench

- Run controller placed between the host stream interface and the kernel top-level (single-clock ivalid/iready/ovalid/oready datapath).
- Each run moves exactly n_items input beats into the kernel and collects exactly n_items output beats, then reports completion.
- Caps the number of items in flight to protect downstream buffering.
- Exposes beat counters for host status registers.

---
 rtl/kernel_stream_sequencer.sv | 108 ++++++++++
 tb/tb_kernel_stream_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_stream_sequencer.sv
// Run controller between the host stream and the kernel: admits exactly n_items
// input beats, forwards exactly n_items output beats and caps items in flight.
module kernel_stream_sequencer #(
  parameter int CNTW        = 32,
  parameter int MAXINFLIGHT = 64,
  parameter int IFW         = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [CNTW-1:0] n_items,
  output logic            busy,
  output logic            done,
  input  logic            src_valid,
  output logic            src_ready,
  output logic            k_ivalid,
  input  logic            k_iready,
  input  logic            k_ovalid,
  output logic            k_oready,
  output logic            snk_valid,
  input  logic            snk_ready,
  output logic [CNTW-1:0] in_count,
  output logic [CNTW-1:0] out_count,
  output logic [IFW-1:0]  inflight,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [IFW-1:0] MAX_IF = IFW'(MAXINFLIGHT);

  state_t          state;
  logic [CNTW-1:0] n;
  logic            in_en;
  logic            out_en;
  logic            in_fire;
  logic            out_fire;
  logic [CNTW-1:0] in_count_nx;
  logic [CNTW-1:0] out_count_nx;

  // Handshakes: a beat transfers on an edge where valid and ready are both high.
  // Gating depends only on registered state, so start/abort/n_items never reach
  // the handshake outputs combinationally.
  assign in_en  = (state == RUN) && (in_count < n) && (inflight < MAX_IF);
  assign out_en = ((state == RUN) || (state == DRAIN)) && (out_count < n);

  assign k_ivalid  = src_valid & in_en;
  assign src_ready = k_iready & in_en;
  assign snk_valid = k_ovalid & out_en;
  assign k_oready  = snk_ready & out_en;

  assign in_fire  = k_ivalid & k_iready;
  assign out_fire = snk_valid & snk_ready;

  assign in_count_nx  = in_count + {{(CNTW-1){1'b0}}, in_fire};
  assign out_count_nx = out_count + {{(CNTW-1){1'b0}}, out_fire};

  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      n         <= '0;
      in_count  <= '0;
      out_count <= '0;
      inflight  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n         <= n_items;
            in_count  <= '0;
            out_count <= '0;
            inflight  <= '0;
            state     <= (n_items == '0) ? DONE : RUN;
          end
        end
        RUN, DRAIN: begin
          in_count  <= in_count_nx;
          out_count <= out_count_nx;
          case ({in_fire, out_fire})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
          endcase
          // Abort wins over completion; last in and last out on one edge skips DRAIN.
          if (abort)
            state <= IDLE;
          else if (out_count_nx == n)
            state <= DONE;
          else if ((state == RUN) && (in_count_nx == n))
            state <= DRAIN;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_stream_sequencer.sv
// Directed bench for kernel_stream_sequencer with a FIFO kernel model and an
// output scoreboard fed from accepted input beats.
module tb_kernel_stream_sequencer;

  localparam int CNTW = 32;
  localparam int MAXIF = 2;
  localparam int IFW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [CNTW-1:0] n_items = '0;
  logic            busy, done;
  logic            src_valid = 1'b0;
  logic            src_ready;
  logic            k_ivalid;
  logic            k_iready = 1'b1;
  logic            k_ovalid;
  logic            k_oready;
  logic            snk_valid;
  logic            snk_ready = 1'b0;
  logic [CNTW-1:0] in_count, out_count;
  logic [IFW-1:0]  inflight;
  logic [1:0]      state_dbg;

  int checks = 0;
  int errors = 0;

  // Kernel model: in-order FIFO, output valid one cycle after an accepted input.
  logic [7:0] kfifo[$];
  int         kcnt = 0;
  logic [7:0] k_head = 8'hEE;
  logic [7:0] src_data = 8'd0;
  logic       extra_ovalid = 1'b0;
  logic       in_f = 1'b0, out_f = 1'b0;

  logic [7:0] exp_q[$];
  int done_cnt = 0, tb_in = 0, tb_out = 0, cap_viol = 0;
  logic seen_drain = 1'b0, kiv_seen = 1'b0, snkv_seen = 1'b0;

  assign k_ovalid = (kcnt != 0) | extra_ovalid;

  kernel_stream_sequencer #(.CNTW(CNTW), .MAXINFLIGHT(MAXIF), .IFW(IFW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n_items(n_items),
    .busy(busy), .done(done),
    .src_valid(src_valid), .src_ready(src_ready),
    .k_ivalid(k_ivalid), .k_iready(k_iready),
    .k_ovalid(k_ovalid), .k_oready(k_oready),
    .snk_valid(snk_valid), .snk_ready(snk_ready),
    .in_count(in_count), .out_count(out_count), .inflight(inflight),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic kernel_flush();
    kfifo.delete();
    exp_q.delete();
    kcnt = 0;
    k_head = 8'hEE;
  endtask

  task automatic next_cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [CNTW-1:0] n);
    done_cnt = 0; tb_in = 0; tb_out = 0;
    seen_drain = 1'b0; kiv_seen = 1'b0; snkv_seen = 1'b0;
    start = 1'b1;
    n_items = n;
    next_cycle(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit found = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        found = 1;
        break;
      end
      next_cycle(1);
    end
    if (!found) begin
      errors++;
      checks++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  // Monitor: samples mid-cycle, records fires, pops and compares outputs.
  always @(negedge clk) begin
    if (!rst) begin
      in_f  = 1'b0;
      out_f = 1'b0;
    end else begin
      in_f  = k_ivalid & k_iready;
      out_f = snk_valid & snk_ready;
      if (done) done_cnt++;
      if (state_dbg == 2'd2) seen_drain = 1'b1;
      if (k_ivalid) kiv_seen = 1'b1;
      if (snk_valid) snkv_seen = 1'b1;
      if (inflight > IFW'(MAXIF)) cap_viol++;
      if (in_f) begin
        tb_in++;
        exp_q.push_back(src_data ^ 8'hA5);
      end
      if (out_f) begin
        tb_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_beat: got 0x%0h expected no beat", k_head ^ 8'hA5);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if ((k_head ^ 8'hA5) !== e) begin
            errors++;
            $display("FAIL out_beat: got 0x%0h expected 0x%0h", k_head ^ 8'hA5, e);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      if (out_f && kfifo.size() != 0) void'(kfifo.pop_front());
      if (in_f) begin
        kfifo.push_back(src_data);
        src_data = src_data + 8'd1;
      end
      kcnt = kfifo.size();
      k_head = (kcnt != 0) ? kfifo[0] : 8'hEE;
    end
  end

  initial begin
    kernel_flush();
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_count", in_count, 0);
    check("rst_out_count", out_count, 0);
    check("rst_inflight", inflight, 0);
    check("rst_state", state_dbg, 0);
    #20 rst = 1'b1;
    next_cycle(2);

    // 1. basic run, n=4
    src_valid = 1'b1; snk_ready = 1'b1;
    start_run(4);
    check("t1_state_run", state_dbg, 1);
    wait_done("t1_done", 40);
    next_cycle(2);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_seen_drain", seen_drain, 1);
    check("t1_in_count", in_count, 4);
    check("t1_out_count", out_count, 4);
    check("t1_inflight", inflight, 0);
    check("t1_in_fires", tb_in, 4);
    check("t1_out_fires", tb_out, 4);
    check("t1_state_idle", state_dbg, 0);
    check("t1_exp_empty", exp_q.size(), 0);

    // 2. zero items
    start_run(0);
    check("t2_state_done", state_dbg, 3);
    check("t2_done", done, 1);
    next_cycle(3);
    check("t2_done_pulses", done_cnt, 1);
    check("t2_kivalid_quiet", kiv_seen, 0);
    check("t2_snkvalid_quiet", snkv_seen, 0);
    check("t2_in_count", in_count, 0);
    check("t2_out_count", out_count, 0);

    // 3. credit limit, n=8 with sink stalled
    snk_ready = 1'b0;
    start_run(8);
    next_cycle(6);
    check("t3_in_stall", in_count, 2);
    check("t3_inflight_cap", inflight, 2);
    check("t3_src_ready_low", src_ready, 0);
    snk_ready = 1'b1;
    wait_done("t3_done", 80);
    next_cycle(2);
    check("t3_in_count", in_count, 8);
    check("t3_out_count", out_count, 8);
    check("t3_inflight", inflight, 0);
    check("t3_exp_empty", exp_q.size(), 0);

    // 4. overrun protection, n=5 with upstream always valid
    start_run(5);
    for (int i = 0; i < 40 && in_count != 5; i++) next_cycle(1);
    check("t4_in_count_sat", in_count, 5);
    check("t4_state_drain", state_dbg, 2);
    check("t4_src_ready_low", src_ready, 0);
    check("t4_kivalid_low", k_ivalid, 0);
    wait_done("t4_done", 40);
    next_cycle(1);
    extra_ovalid = 1'b1;
    #1;
    check("t4_snk_valid_blocked", snk_valid, 0);
    check("t4_k_oready_low", k_oready, 0);
    next_cycle(3);
    extra_ovalid = 1'b0;
    check("t4_in_count_held", in_count, 5);
    check("t4_out_count", out_count, 5);
    check("t4_exp_empty", exp_q.size(), 0);

    // 5. abort at in_count=3 of 10
    start_run(10);
    for (int i = 0; i < 40 && in_count != 3; i++) next_cycle(1);
    src_valid = 1'b0;
    abort = 1'b1;
    next_cycle(1);
    abort = 1'b0;
    check("t5_state_idle", state_dbg, 0);
    check("t5_busy", busy, 0);
    next_cycle(3);
    check("t5_no_done", done_cnt, 0);
    check("t5_in_count_held", in_count, 3);
    kernel_flush();
    start_run(2);
    check("t5_cleared_in", in_count, 0);
    check("t5_cleared_out", out_count, 0);
    src_valid = 1'b1;
    wait_done("t5_done", 40);
    next_cycle(2);
    check("t5_in_count", in_count, 2);
    check("t5_out_count", out_count, 2);
    check("t5_exp_empty", exp_q.size(), 0);

    // 6. async reset while draining
    snk_ready = 1'b0;
    start_run(2);
    for (int i = 0; i < 40 && state_dbg != 2'd2; i++) next_cycle(1);
    check("t6_state_drain", state_dbg, 2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_in_count", in_count, 0);
    check("t6_out_count", out_count, 0);
    check("t6_inflight", inflight, 0);
    check("t6_state", state_dbg, 0);
    kernel_flush();
    next_cycle(1);
    rst = 1'b1;
    snk_ready = 1'b1;
    next_cycle(1);
    start_run(1);
    wait_done("t6_done", 40);
    next_cycle(2);
    check("t6_done_pulses", done_cnt, 1);
    check("t6_in_count_after", in_count, 1);
    check("t6_out_count_after", out_count, 1);
    check("t6_exp_empty", exp_q.size(), 0);

    check("cap_never_exceeded", cap_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
